// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory interface.
package cpu_mem_pkg;

  localparam int DMEM_DEPTH  = 128;
  localparam int DWORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        is_store;
    logic        fault;
  } lsu_resp_t;

  // An address faults when it is past the memory or not on a doubleword slot.
  function automatic logic addr_fault(input logic [63:0] addr,
                                      input logic [63:0] limit,
                                      input logic        align_chk);
    logic misaligned;
    misaligned = (addr & 64'(DWORD_BYTES - 1)) != 64'd0;
    return (addr >= limit) || (align_chk && misaligned);
  endfunction

endpackage

// File: rtl/lsu_stat_counters.sv
// Load/store/fault debug counters; each wraps modulo 2^CNT_W.
module lsu_stat_counters #(
  parameter int CNT_W = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             i_load_inc,
  input  logic             i_store_inc,
  input  logic             i_fault_inc,
  output logic [CNT_W-1:0] o_load_count,
  output logic [CNT_W-1:0] o_store_count,
  output logic [CNT_W-1:0] o_fault_count
);

  logic [CNT_W-1:0] r_load_count;
  logic [CNT_W-1:0] r_store_count;
  logic [CNT_W-1:0] r_fault_count;

  // Count completed loads, completed stores and faulting requests.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_load_count  <= '0;
      r_store_count <= '0;
      r_fault_count <= '0;
    end else begin
      if (i_load_inc)  r_load_count  <= r_load_count  + CNT_W'(1);
      if (i_store_inc) r_store_count <= r_store_count + CNT_W'(1);
      if (i_fault_inc) r_fault_count <= r_fault_count + CNT_W'(1);
    end
  end

  assign o_load_count  = r_load_count;
  assign o_store_count = r_store_count;
  assign o_fault_count = r_fault_count;

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one LDUR/STUR at a time, tagged response with fault.
module load_store_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_LIMIT  = DMEM_DEPTH,
  parameter int ALIGN_CHECK = 1,
  parameter int CNT_W       = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic [4:0]       resp_rd,
  output logic             resp_is_store,
  output logic             resp_fault,
  output logic [63:0]      mem_address,
  output logic [63:0]      mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [63:0]      mem_read_data,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] fault_count
);

  lsu_state_e  r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  lsu_resp_t   r_resp;
  logic [63:0] r_mem_address;
  logic [63:0] r_mem_write_data;
  logic        r_mem_read;
  logic        r_mem_write;

  logic w_fault;
  logic w_load_inc;
  logic w_store_inc;
  logic w_fault_inc;

  assign w_fault     = addr_fault(req_addr, 64'(ADDR_LIMIT), ALIGN_CHECK != 0);
  assign w_load_inc  = (r_state == ACCESS) && r_mem_read;
  assign w_store_inc = (r_state == ACCESS) && r_mem_write;
  assign w_fault_inc = (r_state == IDLE) && req_valid && w_fault;

  // Request/response FSM; every output it drives is a register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state          <= IDLE;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp           <= '0;
      r_mem_address    <= 64'd0;
      r_mem_write_data <= 64'd0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready     <= 1'b0;
            r_resp.rd       <= req_rd;
            r_resp.is_store <= req_is_store;
            if (w_fault) begin
              // Faulting requests never touch memory and answer one edge later.
              r_resp.fault <= 1'b1;
              r_resp.data  <= 64'd0;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_resp.fault     <= 1'b0;
              r_mem_address    <= req_addr;
              r_mem_write_data <= req_wdata;
              r_mem_read       <= ~req_is_store;
              r_mem_write      <= req_is_store;
              r_state          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Memory returned read data on the negedge; a write commits at this edge.
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_resp.data  <= r_mem_read ? mem_read_data : 64'd0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
        end
      endcase
    end
  end

  lsu_stat_counters #(.CNT_W(CNT_W)) u_stats (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .i_load_inc    (w_load_inc),
    .i_store_inc   (w_store_inc),
    .i_fault_inc   (w_fault_inc),
    .o_load_count  (load_count),
    .o_store_count (store_count),
    .o_fault_count (fault_count)
  );

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp.data;
  assign resp_rd        = r_resp.rd;
  assign resp_is_store  = r_resp.is_store;
  assign resp_fault     = r_resp.fault;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;

endmodule
